// File: rtl/spi_ram_arbiter.sv
// SPI command decoder and two-requester RAM arbiter.
// Shares one single-port sync RAM between the SPI slave and a host port.
module spi_ram_arbiter #(
    parameter int ADDR_WIDTH = 8,
    parameter int TX_HOLD    = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [9:0]            rx_data,
    input  logic                  rx_valid,
    output logic [7:0]            tx_data,
    output logic                  tx_valid,
    input  logic                  host_req,
    input  logic                  host_we,
    input  logic [ADDR_WIDTH-1:0] host_addr,
    input  logic [7:0]            host_wdata,
    output logic                  host_gnt,
    output logic                  host_rvalid,
    output logic [7:0]            host_rdata,
    output logic                  ram_en,
    output logic                  ram_we,
    output logic [ADDR_WIDTH-1:0] ram_addr,
    output logic [7:0]            ram_wdata,
    input  logic [7:0]            ram_rdata,
    output logic                  spi_ovf
);

    typedef enum logic {
        IDLE,
        ISSUE
    } state_t;

    localparam int CW = $clog2(TX_HOLD + 1);
    localparam logic [CW-1:0] TX_LAST = CW'(TX_HOLD - 1);

    state_t                state;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  spi_pend;
    logic                  spi_pwe;
    logic [ADDR_WIDTH-1:0] spi_paddr;
    logic [7:0]            spi_pwdata;
    logic                  rr_spi;
    logic                  ram_tag_spi;
    logic                  rd_pend;
    logic                  rd_spi;
    logic [CW-1:0]         tx_cnt;

    logic [1:0]            op;
    logic [7:0]            payload;
    logic                  spi_rd_busy;
    logic                  spi_elig;
    logic                  host_elig;
    logic                  spi_win;
    logic                  host_win;

    // Eligibility and round-robin winner selection for the IDLE cycle
    always_comb begin
        op          = rx_data[9:8];
        payload     = rx_data[7:0];
        spi_rd_busy = tx_valid | (rd_pend & rd_spi);
        spi_elig    = spi_pend & (spi_pwe | ~spi_rd_busy);
        host_elig   = host_req;
        spi_win     = (state == IDLE) & spi_elig & (~host_elig | ~rr_spi);
        host_win    = (state == IDLE) & host_elig & ~spi_win;
    end

    // Access FSM: launch one RAM access, then one idle cycle
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= IDLE;
            ram_en      <= 1'b0;
            ram_we      <= 1'b0;
            ram_addr    <= '0;
            ram_wdata   <= '0;
            ram_tag_spi <= 1'b0;
            host_gnt    <= 1'b0;
            rr_spi      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (spi_win | host_win) begin
                        ram_en      <= 1'b1;
                        host_gnt    <= host_win;
                        ram_tag_spi <= spi_win;
                        rr_spi      <= spi_win;
                        state       <= ISSUE;
                        if (spi_win) begin
                            ram_we    <= spi_pwe;
                            ram_addr  <= spi_paddr;
                            ram_wdata <= spi_pwdata;
                        end else begin
                            ram_we    <= host_we;
                            ram_addr  <= host_addr;
                            ram_wdata <= host_wdata;
                        end
                    end
                end
                ISSUE: begin
                    ram_en   <= 1'b0;
                    ram_we   <= 1'b0;
                    host_gnt <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // SPI command decode into address registers and the single pending slot
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_addr    <= '0;
            rd_addr    <= '0;
            spi_pend   <= 1'b0;
            spi_pwe    <= 1'b0;
            spi_paddr  <= '0;
            spi_pwdata <= '0;
            spi_ovf    <= 1'b0;
        end else begin
            if (spi_win)
                spi_pend <= 1'b0;
            if (rx_valid) begin
                case (op)
                    2'b00: wr_addr <= payload[ADDR_WIDTH-1:0];
                    2'b10: rd_addr <= payload[ADDR_WIDTH-1:0];
                    default: begin
                        if (spi_pend & ~spi_win) begin
                            spi_ovf <= 1'b1;
                        end else begin
                            spi_pend   <= 1'b1;
                            spi_pwe    <= ~op[1];
                            spi_paddr  <= op[1] ? rd_addr : wr_addr;
                            spi_pwdata <= payload;
                        end
                    end
                endcase
            end
        end
    end

    // Read return: tag follows the access, data captured a cycle later
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_pend     <= 1'b0;
            rd_spi      <= 1'b0;
            host_rvalid <= 1'b0;
            host_rdata  <= '0;
            tx_valid    <= 1'b0;
            tx_data     <= '0;
            tx_cnt      <= '0;
        end else begin
            rd_pend     <= ram_en & ~ram_we;
            rd_spi      <= ram_tag_spi;
            host_rvalid <= 1'b0;
            if (rd_pend & ~rd_spi) begin
                host_rvalid <= 1'b1;
                host_rdata  <= ram_rdata;
            end
            if (rd_pend & rd_spi) begin
                tx_valid <= 1'b1;
                tx_data  <= ram_rdata;
                tx_cnt   <= TX_LAST;
            end else if (tx_valid) begin
                if (tx_cnt == '0)
                    tx_valid <= 1'b0;
                else
                    tx_cnt <= tx_cnt - CW'(1);
            end
        end
    end

endmodule

// File: tb/tb_spi_ram_arbiter.sv
// Bench for spi_ram_arbiter: schedule-based reference model plus
// directed scenarios with literal expectations.
module tb_spi_ram_arbiter;

    localparam int AW  = 8;
    localparam int TXH = 8;
    localparam int NC  = 1024;

    logic          clk = 1'b0;
    logic          rst;
    logic [9:0]    rx_data;
    logic          rx_valid;
    logic [7:0]    tx_data;
    logic          tx_valid;
    logic          host_req;
    logic          host_we;
    logic [AW-1:0] host_addr;
    logic [7:0]    host_wdata;
    logic          host_gnt;
    logic          host_rvalid;
    logic [7:0]    host_rdata;
    logic          ram_en;
    logic          ram_we;
    logic [AW-1:0] ram_addr;
    logic [7:0]    ram_wdata;
    logic [7:0]    ram_rdata = 8'h00;
    logic          spi_ovf;

    spi_ram_arbiter #(
        .ADDR_WIDTH(AW),
        .TX_HOLD   (TXH)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .host_req   (host_req),
        .host_we    (host_we),
        .host_addr  (host_addr),
        .host_wdata (host_wdata),
        .host_gnt   (host_gnt),
        .host_rvalid(host_rvalid),
        .host_rdata (host_rdata),
        .ram_en     (ram_en),
        .ram_we     (ram_we),
        .ram_addr   (ram_addr),
        .ram_wdata  (ram_wdata),
        .ram_rdata  (ram_rdata),
        .spi_ovf    (spi_ovf)
    );

    always #5 clk = ~clk;

    // Single-port synchronous RAM
    logic [7:0] ram [256];
    always @(posedge clk) begin
        if (ram_en) begin
            if (ram_we)
                ram[ram_addr] <= ram_wdata;
            else
                ram_rdata <= ram[ram_addr];
        end
    end

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%h want=%h", nm, cyc, act, exp);
        end
    endtask

    // Reference model: expected outputs scheduled by cycle number
    bit         e_en  [NC];
    bit         e_we  [NC];
    bit         e_gnt [NC];
    bit         e_rv  [NC];
    logic [7:0] e_addr[NC];
    logic [7:0] e_wd  [NC];
    logic [7:0] e_rd  [NC];
    logic [7:0] mem_m [256];
    int         next_free;
    int         spi_rd_ok;
    int         tx_start;
    logic [7:0] tx_val;
    bit         m_pend;
    bit         m_pwe;
    logic [7:0] m_paddr;
    logic [7:0] m_pwd;
    logic [7:0] m_wa;
    logic [7:0] m_ra;
    bit         last_spi;
    bit         m_ovf;

    task automatic m_reset();
        for (int i = 0; i < NC; i++) begin
            e_en[i]  = 1'b0;
            e_we[i]  = 1'b0;
            e_gnt[i] = 1'b0;
            e_rv[i]  = 1'b0;
        end
        next_free = 0;
        spi_rd_ok = 0;
        tx_start  = -1;
        m_pend    = 1'b0;
        m_wa      = 8'h00;
        m_ra      = 8'h00;
        last_spi  = 1'b0;
        m_ovf     = 1'b0;
    endtask

    task automatic m_step(input int c);
        bit         se;
        bit         he;
        bit         sw;
        bit         hw;
        logic [1:0] op;
        logic [7:0] pl;
        if (c >= next_free) begin
            se = m_pend && (m_pwe || c >= spi_rd_ok);
            he = host_req;
            sw = se && (!he || !last_spi);
            hw = he && !sw;
            if (sw) begin
                e_en[c+1]   = 1'b1;
                e_we[c+1]   = m_pwe;
                e_addr[c+1] = m_paddr;
                e_wd[c+1]   = m_pwd;
                if (m_pwe) begin
                    mem_m[m_paddr] = m_pwd;
                end else begin
                    tx_start  = c + 3;
                    tx_val    = mem_m[m_paddr];
                    spi_rd_ok = c + 3 + TXH;
                end
                m_pend    = 1'b0;
                last_spi  = 1'b1;
                next_free = c + 2;
            end else if (hw) begin
                e_en[c+1]   = 1'b1;
                e_gnt[c+1]  = 1'b1;
                e_we[c+1]   = host_we;
                e_addr[c+1] = host_addr;
                e_wd[c+1]   = host_wdata;
                if (host_we) begin
                    mem_m[host_addr] = host_wdata;
                end else begin
                    e_rv[c+3] = 1'b1;
                    e_rd[c+3] = mem_m[host_addr];
                end
                last_spi  = 1'b0;
                next_free = c + 2;
            end
        end
        if (rx_valid) begin
            op = rx_data[9:8];
            pl = rx_data[7:0];
            if (op == 2'd0) begin
                m_wa = pl;
            end else if (op == 2'd2) begin
                m_ra = pl;
            end else if (m_pend) begin
                m_ovf = 1'b1;
            end else begin
                m_pend  = 1'b1;
                m_pwe   = (op == 2'd1);
                m_paddr = (op == 2'd1) ? m_wa : m_ra;
                m_pwd   = pl;
            end
        end
    endtask

    // Compare process: checks every cycle, then advances the model
    always @(negedge clk) begin
        int  c;
        bit  txe;
        c = cyc;
        if (rst) begin
            m_reset();
            chk("rst_ram_en", ram_en, 0);
            chk("rst_ram_we", ram_we, 0);
            chk("rst_ram_addr", ram_addr, 0);
            chk("rst_ram_wdata", ram_wdata, 0);
            chk("rst_host_gnt", host_gnt, 0);
            chk("rst_host_rvalid", host_rvalid, 0);
            chk("rst_host_rdata", host_rdata, 0);
            chk("rst_tx_valid", tx_valid, 0);
            chk("rst_tx_data", tx_data, 0);
            chk("rst_spi_ovf", spi_ovf, 0);
        end else if (c + 4 < NC) begin
            chk("ram_en", ram_en, e_en[c]);
            if (e_en[c]) begin
                chk("ram_we", ram_we, e_we[c]);
                chk("ram_addr", ram_addr, e_addr[c]);
                if (e_we[c])
                    chk("ram_wdata", ram_wdata, e_wd[c]);
            end
            chk("host_gnt", host_gnt, e_gnt[c]);
            chk("host_rvalid", host_rvalid, e_rv[c]);
            if (e_rv[c])
                chk("host_rdata", host_rdata, e_rd[c]);
            txe = (tx_start >= 0) && (c >= tx_start) && (c < tx_start + TXH);
            chk("tx_valid", tx_valid, txe);
            if (txe)
                chk("tx_data", tx_data, tx_val);
            chk("spi_ovf", spi_ovf, m_ovf);
            m_step(c);
        end
    end

    // Event counters for burst / access tallies
    int tx_rises = 0;
    int en_cnt   = 0;
    bit tx_prev  = 1'b0;
    always @(negedge clk) begin
        if (tx_valid && !tx_prev)
            tx_rises++;
        tx_prev = tx_valid;
        if (ram_en)
            en_cnt++;
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [9:0] w);
        rx_valid = 1'b1;
        rx_data  = w;
        step();
        rx_valid = 1'b0;
    endtask

    task automatic look();
        #3;
    endtask

    int r0;
    int n0;

    initial begin
        rst        = 1'b1;
        rx_valid   = 1'b0;
        rx_data    = '0;
        host_req   = 1'b0;
        host_we    = 1'b0;
        host_addr  = '0;
        host_wdata = '0;
        for (int i = 0; i < 256; i++) begin
            ram[i]   = 8'(i) ^ 8'hB5;
            mem_m[i] = 8'(i) ^ 8'hB5;
        end
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;

        // SPI write
        send(10'h02A);
        send(10'h15C);
        step();
        look();
        chk("t1_en", ram_en, 1);
        chk("t1_we", ram_we, 1);
        chk("t1_addr", ram_addr, 8'h2A);
        chk("t1_wdata", ram_wdata, 8'h5C);
        step();
        look();
        chk("t1_en_off", ram_en, 0);

        // SPI read back
        send(10'h22A);
        send(10'h300);
        step();
        look();
        chk("t2_en", ram_en, 1);
        chk("t2_we", ram_we, 0);
        chk("t2_addr", ram_addr, 8'h2A);
        step();
        step();
        look();
        chk("t2_tx_first", tx_valid, 1);
        chk("t2_tx_data", tx_data, 8'h5C);
        repeat (7) step();
        look();
        chk("t2_tx_last", tx_valid, 1);
        step();
        look();
        chk("t2_tx_end", tx_valid, 0);

        // Host read
        host_req  = 1'b1;
        host_we   = 1'b0;
        host_addr = 8'h10;
        step();
        host_req = 1'b0;
        look();
        chk("t3_gnt", host_gnt, 1);
        chk("t3_addr", ram_addr, 8'h10);
        step();
        look();
        chk("t3_gnt_off", host_gnt, 0);
        step();
        look();
        chk("t3_rvalid", host_rvalid, 1);
        chk("t3_rdata", host_rdata, 8'hA5);
        step();
        look();
        chk("t3_rvalid_off", host_rvalid, 0);

        // Contention right after reset
        step();
        rst = 1'b1;
        step();
        rst = 1'b0;
        send(10'h040);
        send(10'h111);
        host_req   = 1'b1;
        host_we    = 1'b1;
        host_addr  = 8'h41;
        host_wdata = 8'h22;
        step();
        look();
        chk("t4_spi_first", ram_addr, 8'h40);
        chk("t4_spi_wd", ram_wdata, 8'h11);
        chk("t4_no_gnt", host_gnt, 0);
        step();
        step();
        host_req = 1'b0;
        look();
        chk("t4_host_gnt", host_gnt, 1);
        chk("t4_host_addr", ram_addr, 8'h41);
        send(10'h133);
        host_req   = 1'b1;
        host_addr  = 8'h42;
        host_wdata = 8'h44;
        step();
        look();
        chk("t4_tie2_spi", ram_wdata, 8'h33);
        chk("t4_tie2_gnt", host_gnt, 0);
        step();
        step();
        host_req = 1'b0;
        look();
        chk("t4_host2_gnt", host_gnt, 1);
        chk("t4_host2_addr", ram_addr, 8'h42);

        // New SPI command in the cycle the previous one is granted
        step();
        send(10'h155);
        send(10'h166);
        look();
        chk("t7_en", ram_en, 1);
        chk("t7_wd", ram_wdata, 8'h55);
        chk("t7_no_ovf", spi_ovf, 0);
        step();
        step();
        look();
        chk("t7_second_wd", ram_wdata, 8'h66);
        chk("t7_no_ovf2", spi_ovf, 0);

        // Overflow while a blocked SPI read is pending
        step();
        r0 = tx_rises;
        send(10'h241);
        send(10'h300);
        repeat (4) step();
        send(10'h3AA);
        step();
        send(10'h3BB);
        look();
        chk("t5_ovf", spi_ovf, 1);
        repeat (7) step();
        look();
        chk("t5_burst2", tx_valid, 1);
        chk("t5_burst2_data", tx_data, 8'h22);
        repeat (13) step();
        look();
        chk("t5_bursts", tx_rises - r0, 2);
        chk("t5_tx_idle", tx_valid, 0);

        // Reset in the third tx_valid cycle
        send(10'h300);
        repeat (4) step();
        look();
        chk("t6_tx_on", tx_valid, 1);
        step();
        rst = 1'b1;
        look();
        chk("t6_tx_off", tx_valid, 0);
        chk("t6_ovf_off", spi_ovf, 0);
        chk("t6_en_off", ram_en, 0);
        chk("t6_gnt_off", host_gnt, 0);
        step();
        rst = 1'b0;
        n0 = en_cnt;
        r0 = tx_rises;
        repeat (15) step();
        look();
        chk("t6_no_access", en_cnt - n0, 0);
        chk("t6_no_burst", tx_rises - r0, 0);
        chk("t6_no_rvalid", host_rvalid, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
